// File: rtl/tuner_ctrl.sv
// tuner_ctrl: FM tuner sequencer. Tunes or seeks the DDS phase constant K,
// waits for the front end to settle, averages RSSI over 2^DWELL_LOG2
// samples and decides whether a station is present.
//
// Optional feature macro: TUNER_CTRL_AUTOMUTE_EN
//   When defined, IDLE runs continuous RSSI measurements and drives
//   mute = !hit after each one. At the end of a command, mute = !found.
//   When undefined, mute drops to 0 at the end of every command.
//
// Ports
//   clk          audio-rate clock
//   reset        asynchronous active-low reset
//   cmd_valid    command request
//   cmd_ready    high in IDLE; a command is accepted on cmd_valid & cmd_ready
//   cmd_op       00 tune, 01 seek up, 10 seek down, 11 abort
//   cmd_ch       target channel for tune (values >= N_CH are clamped)
//   rssi         unsigned signal magnitude, one sample per clk
//   rssi_thresh  unsigned station threshold
//   K            DDS phase constant
//   channel      current channel index
//   mute         audio mute
//   busy         operation in progress
//   done         one-cycle completion pulse
//   found        last measurement was at or above the threshold
module tuner_ctrl #(
   parameter int unsigned width_dds  = 32,
   parameter int unsigned K_MIN      = 1565873493,
   parameter int unsigned K_STEP     = 1789570,
   parameter int unsigned N_CH       = 206,
   parameter int unsigned SETTLE     = 64,
   parameter int unsigned DWELL_LOG2 = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [7:0]           cmd_ch,
   input  logic [16:0]          rssi,
   input  logic [16:0]          rssi_thresh,
   output logic [width_dds-1:0] K,
   output logic [7:0]           channel,
   output logic                 mute,
   output logic                 busy,
   output logic                 done,
   output logic                 found
);

   localparam int unsigned ACC_W  = 17 + DWELL_LOG2;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned N_SAMP = 1 << DWELL_LOG2;

   localparam logic [7:0]           CH_LAST = 8'(N_CH - 1);
   localparam logic [width_dds-1:0] K_BASE  = width_dds'(K_MIN);
   localparam logic [width_dds-1:0] K_INC   = width_dds'(K_STEP);
   localparam logic [width_dds-1:0] K_TOP   = width_dds'(K_MIN + (N_CH - 1) * K_STEP);

   localparam logic [1:0] OP_TUNE  = 2'b00;
   localparam logic [1:0] OP_UP    = 2'b01;
   localparam logic [1:0] OP_ABORT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RETUNE,
      S_SETTLE,
      S_MEASURE,
      S_DECIDE
   } state_t;

   state_t               state;
   logic [ACC_W-1:0]     acc;
   logic [CNT_W-1:0]     cnt;
   logic [width_dds-1:0] k_acc;    // running sum for multi-cycle tune
   logic [7:0]           target;   // tune destination channel
   logic [7:0]           start_ch; // channel a seek started from
   logic [7:0]           visited;  // seek steps taken so far
   logic                 seek;
   logic                 up;
   logic                 ret;      // seek exhausted, returning to start_ch

   logic                 abort_c;
   logic                 fin_c;
   logic                 fin_found_c;
   logic                 hit_c;
   logic [16:0]          avg_c;
   logic [7:0]           tgt_c;

`ifdef TUNER_CTRL_AUTOMUTE_EN
   logic                 primed;   // a command has completed since reset
   logic [ACC_W-1:0]     acc_next_c;
   logic [16:0]          avg_next_c;

   // Average including the current sample, for the last IDLE sample
   assign acc_next_c = acc + ACC_W'(rssi);
   assign avg_next_c = acc_next_c[ACC_W-1:DWELL_LOG2];
`endif

   // Decision, clamp and end-of-command detection
   always_comb begin
      avg_c       = acc[ACC_W-1:DWELL_LOG2];
      hit_c       = (avg_c >= rssi_thresh);
      tgt_c       = (32'(cmd_ch) >= N_CH) ? CH_LAST : cmd_ch;
      abort_c     = (state != S_IDLE) && cmd_valid && (cmd_op == OP_ABORT);
      fin_c       = 1'b0;
      fin_found_c = 1'b0;
      if (abort_c) begin
         fin_c = 1'b1;
      end else if ((state == S_SETTLE) && ret && (cnt == CNT_W'(SETTLE - 1))) begin
         fin_c = 1'b1;
      end else if ((state == S_DECIDE) && (!seek || hit_c)) begin
         fin_c       = 1'b1;
         fin_found_c = hit_c;
      end
   end

   // Sequencer and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         acc       <= '0;
         cnt       <= '0;
         k_acc     <= K_BASE;
         target    <= '0;
         start_ch  <= '0;
         visited   <= '0;
         seek      <= 1'b0;
         up        <= 1'b0;
         ret       <= 1'b0;
         K         <= K_BASE;
         channel   <= '0;
         mute      <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         found     <= 1'b0;
         cmd_ready <= 1'b0;
`ifdef TUNER_CTRL_AUTOMUTE_EN
         primed    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (fin_c) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            found     <= fin_found_c;
            cmd_ready <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            ret       <= 1'b0;
`ifdef TUNER_CTRL_AUTOMUTE_EN
            mute      <= !fin_found_c;
            primed    <= 1'b1;
`else
            mute      <= 1'b0;
`endif
         end else begin
            case (state)
               S_IDLE: begin
                  cmd_ready <= 1'b1;
                  if (cmd_ready && cmd_valid && (cmd_op != OP_ABORT)) begin
                     state     <= S_RETUNE;
                     cmd_ready <= 1'b0;
                     busy      <= 1'b1;
                     mute      <= 1'b1;
                     seek      <= (cmd_op != OP_TUNE);
                     up        <= (cmd_op == OP_UP);
                     ret       <= 1'b0;
                     visited   <= '0;
                     start_ch  <= channel;
                     target    <= tgt_c;
                     k_acc     <= K_BASE;
                     cnt       <= '0;
                     acc       <= '0;
                  end
`ifdef TUNER_CTRL_AUTOMUTE_EN
                  // Background squelch measurement while idle
                  else if (primed) begin
                     if (cnt == CNT_W'(N_SAMP - 1)) begin
                        mute <= !(avg_next_c >= rssi_thresh);
                        acc  <= '0;
                        cnt  <= '0;
                     end else begin
                        acc  <= acc_next_c;
                        cnt  <= cnt + CNT_W'(1);
                     end
                  end
`endif
               end

               S_RETUNE: begin
                  if (seek && !ret) begin
                     // Single-step seek with wrap at both ends of the band
                     if (up) begin
                        if (channel == CH_LAST) begin
                           channel <= '0;
                           K       <= K_BASE;
                        end else begin
                           channel <= channel + 8'd1;
                           K       <= K + K_INC;
                        end
                     end else begin
                        if (channel == 8'd0) begin
                           channel <= CH_LAST;
                           K       <= K_TOP;
                        end else begin
                           channel <= channel - 8'd1;
                           K       <= K - K_INC;
                        end
                     end
                     visited <= visited + 8'd1;
                     cnt     <= '0;
                     state   <= S_SETTLE;
                  end else if (cnt == CNT_W'(target)) begin
                     // K and channel change together on the last add cycle
                     K       <= k_acc;
                     channel <= target;
                     cnt     <= '0;
                     state   <= S_SETTLE;
                  end else begin
                     k_acc <= k_acc + K_INC;
                     cnt   <= cnt + CNT_W'(1);
                  end
               end

               S_SETTLE: begin
                  if (cnt == CNT_W'(SETTLE - 1)) begin
                     cnt   <= '0;
                     acc   <= '0;
                     state <= S_MEASURE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               S_MEASURE: begin
                  acc <= acc + ACC_W'(rssi);
                  if (cnt == CNT_W'(N_SAMP - 1)) begin
                     cnt   <= '0;
                     state <= S_DECIDE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               S_DECIDE: begin
                  // Only a seek miss gets here; hits and tunes end via fin_c
                  if (visited == CH_LAST) begin
                     ret    <= 1'b1;
                     target <= start_ch;
                     k_acc  <= K_BASE;
                     cnt    <= '0;
                  end
                  state <= S_RETUNE;
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tuner_ctrl.sv
// tb_tuner_ctrl: directed scoreboard bench for tuner_ctrl with a reduced band
// (K_MIN=1000, K_STEP=10, N_CH=8, SETTLE=4, DWELL_LOG2=2). The stimulus
// process pushes the expected end-of-command result; the monitor pops and
// compares it whenever done pulses.
module tb_tuner_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [7:0]  cmd_ch = 8'd0;
   logic [16:0] rssi;
   logic [16:0] rssi_thresh = 17'd50;
   logic [16:0] rssi_level = 17'd0;
   logic        rssi_mode = 1'b0;
   logic [31:0] K;
   logic [7:0]  channel;
   logic        mute;
   logic        busy;
   logic        done;
   logic        found;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      int k;
      int ch;
      int fnd;
      int lat;
      int ac;
   } exp_t;

   exp_t sb[$];

   // Mode 1: strong signal only on channel 1
   assign rssi = rssi_mode ? ((channel == 8'd1) ? 17'd100 : 17'd0) : rssi_level;

   tuner_ctrl #(
      .width_dds (32),
      .K_MIN     (1000),
      .K_STEP    (10),
      .N_CH      (8),
      .SETTLE    (4),
      .DWELL_LOG2(2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_ch     (cmd_ch),
      .rssi       (rssi),
      .rssi_thresh(rssi_thresh),
      .K          (K),
      .channel    (channel),
      .mute       (mute),
      .busy       (busy),
      .done       (done),
      .found      (found)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_done actual=1 required=0 cycle=%0d", cyc);
         end else begin
            e = sb.pop_front();
            chk("done_K", int'(K), e.k);
            chk("done_channel", int'(channel), e.ch);
            chk("done_found", int'(found), e.fnd);
            chk("done_busy", int'(busy), 0);
            chk("done_mute", int'(mute), 0);
            if (e.lat >= 0) chk("done_latency", cyc - e.ac + 1, e.lat);
         end
      end
   end

   task automatic accept(input logic [1:0] op, input logic [7:0] ch, output int ac);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=0 required=1 cycle=%0d", cyc);
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_ch    = ch;
      @(posedge clk);
      #1;
      ac        = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
         #2;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL done_timeout actual=%0d required=0 pending", sb.size());
         sb.delete();
      end
   endtask

   task automatic run(input logic [1:0] op, input logic [7:0] ch,
                      input int k, input int c, input int f, input int lat);
      int ac;
      accept(op, ch, ac);
      sb.push_back('{k, c, f, lat, ac});
      wait_idle(300);
   endtask

   initial begin
      int ac;

      // Reset and idle state after release
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_K", int'(K), 1000);
      chk("rst_channel", int'(channel), 0);
      chk("rst_mute", int'(mute), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_found", int'(found), 0);

      // Tune to 3 with strong signal
      rssi_level = 17'd100;
      run(2'b00, 8'd3, 1030, 3, 1, 14);

      // Tune to 7, no signal
      rssi_level = 17'd0;
      run(2'b00, 8'd7, 1070, 7, 0, 18);

      // Seek up from 7: wraps to 0 (miss), then 1 (hit)
      rssi_mode = 1'b1;
      run(2'b01, 8'd0, 1010, 1, 1, 21);
      rssi_mode = 1'b0;

      // Seek down from 2 with no signal; a tune issued mid-seek is ignored
      run(2'b00, 8'd2, 1020, 2, 0, 13);
      accept(2'b10, 8'd0, ac);
      sb.push_back('{1020, 2, 0, 78, ac});
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("seek_busy", int'(busy), 1);
      chk("seek_mute", int'(mute), 1);
      chk("seek_cmd_ready", int'(cmd_ready), 0);
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_ch    = 8'd5;
      repeat (3) @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_idle(300);

      // Abort during SETTLE of a seek up from 4
      run(2'b00, 8'd4, 1040, 4, 0, 15);
      accept(2'b01, 8'd0, ac);
      @(posedge clk);
      @(negedge clk);
      chk("abort_pre_channel", int'(channel), 5);
      chk("abort_pre_K", int'(K), 1050);
      chk("abort_pre_cmd_ready", int'(cmd_ready), 0);
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      sb.push_back('{1050, 5, 0, 3, ac});
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      wait_idle(20);

      // Out-of-range tune clamps to the top channel
      run(2'b00, 8'd200, 1070, 7, 0, 18);

      // Reset during MEASURE of a seek down from 7: no done, reset values
      accept(2'b10, 8'd0, ac);
      repeat (6) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_K", int'(K), 1000);
      chk("midrst_channel", int'(channel), 0);
      chk("midrst_mute", int'(mute), 1);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_cmd_ready", int'(cmd_ready), 0);
      chk("midrst_found", int'(found), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_done", int'(done), 0);
      end
      reset = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_rst_cmd_ready", int'(cmd_ready), 1);
      chk("post_rst_mute", int'(mute), 1);
      chk("post_rst_done", int'(done), 0);

      // Threshold boundary: average equal to threshold is a hit, one below is not
      rssi_level = 17'd50;
      run(2'b00, 8'd0, 1000, 0, 1, 11);
      rssi_level = 17'd49;
      run(2'b00, 8'd1, 1010, 1, 0, 12);

      // Abort while idle is ignored
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_abort_busy", int'(busy), 0);
      chk("idle_abort_channel", int'(channel), 1);
      chk("idle_abort_cmd_ready", int'(cmd_ready), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tuner_ctrl.md
TUNER_CTRL -- requirements
Module: tuner_ctrl

Interface
REQ-001 SHALL have parameters: width_dds=32 (DDS word width); K_MIN=1565873493 (K of channel 0, 87.5 MHz at 240 MHz); K_STEP=1789570 (K per 100 kHz channel); N_CH=206 (channels 0..N_CH-1); SETTLE=64 (cycles after retune); DWELL_LOG2=5 (log2 of RSSI samples averaged).
REQ-002 SHALL have ports:
- clk  in  1  audio-rate clock (32 kHz)
- reset  in  1  asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  00 tune, 01 seek up, 10 seek down, 11 abort
- cmd_ch  in  8  target channel for tune
- rssi  in  17  unsigned signal magnitude, one sample per clk
- rssi_thresh  in  17  unsigned station threshold
- K  out  width_dds  DDS phase constant
- channel  out  8  current channel index
- mute  out  1  audio mute
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- found  out  1  last measurement at/above threshold

Function
REQ-003 SHALL implement states IDLE, RETUNE, SETTLE, MEASURE, DECIDE.
REQ-004 cmd_ready SHALL be high only in IDLE; acceptance = cmd_valid & cmd_ready at a rising edge.
REQ-005 On acceptance of a tune/seek: busy=1 and mute=1 from the next cycle until done.
REQ-006 Tune: cmd_ch >= N_CH clamps to N_CH-1; RETUNE computes K_MIN + ch*K_STEP by repeated addition, one add per cycle, ch+1 cycles; K and channel update together in the last RETUNE cycle only.
REQ-007 Seek: channel steps +1 (up) or -1 (down) in a single RETUNE cycle; K +/- K_STEP; wrap N_CH-1 -> 0 (K=K_MIN) and 0 -> N_CH-1 (K=K_MIN+(N_CH-1)*K_STEP).
REQ-008 SETTLE SHALL last exactly SETTLE cycles; rssi ignored.
REQ-009 MEASURE SHALL sum exactly 2^DWELL_LOG2 rssi samples into a (17+DWELL_LOG2)-bit accumulator, no overflow or saturation.
REQ-010 DECIDE (1 cycle): hit = (sum >> DWELL_LOG2) >= rssi_thresh.
REQ-011 Tune: DECIDE always ends; found=hit; done=1 in the following cycle with busy=0.
REQ-012 Seek: on hit, found=1 and end; on miss, step again (REQ-007) unless N_CH-1 channels have been visited, then RETUNE to the start channel (REQ-006 timing), SETTLE, end with found=0 and no MEASURE.
REQ-013 End: done high for exactly one cycle, busy=0, mute=0 (see REQ-018), return to IDLE.
REQ-014 Abort: honored in any non-IDLE state regardless of cmd_ready; next cycle IDLE, K/channel keep current values, found=0, done pulses once; abort in IDLE is ignored.
REQ-015 Other ops with cmd_valid while busy SHALL be ignored (not queued).

Reset
REQ-016 While reset=0 (asynchronous): state IDLE, K=K_MIN, channel=0, mute=1, busy=0, done=0, found=0, cmd_ready=0, accumulator and counters cleared.
REQ-017 First cycle after release: cmd_ready=1, mute stays 1 until first completed command; reset mid-operation discards the operation with no done pulse.

Configuration
REQ-018 Macro TUNER_CTRL_AUTOMUTE_EN: when defined, in IDLE the block runs continuous 2^DWELL_LOG2-sample measurements and sets mute = !hit after each, and on end mute = !found; when undefined, IDLE measurement is absent and mute=0 in IDLE after the first completed command.

Verification (bench params: K_MIN=1000, K_STEP=10, N_CH=8, SETTLE=4, DWELL_LOG2=2)
REQ-019 Reset release, no command -> K=1000, channel=0, mute=1, busy=0, cmd_ready=1.
REQ-020 Tune cmd_ch=3, rssi=100, thresh=50 -> K=1030, channel=3 after 4 RETUNE cycles; done exactly 4+4+4+1+1=14 cycles after acceptance edge; found=1, mute=0.
REQ-021 Channel 7, seek up, rssi=100 only when channel=1 else 0, thresh=50 -> wraps 7->0 (K=1000), miss, 0->1, found=1, K=1010, channel=1.
REQ-022 Channel 2, seek down, rssi=0 throughout -> visits 7 channels, returns to channel 2, K=1020, found=0, single done pulse.
REQ-023 Abort during SETTLE of seek from channel 4 up -> next cycle IDLE, channel=5, K=1050, found=0, done one cycle; tune cmd_ch=200 later -> clamps to channel 7, K=1070.
REQ-024 reset=0 during MEASURE -> outputs at reset values immediately, no done; with TUNER_CTRL_AUTOMUTE_EN, rssi dropping to 10 in IDLE (thresh 50) -> mute=1 within 4+1 cycles.
